// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared defaults, port-count limits and word type for the
//            multi-port register file.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Supported port counts
  localparam int MIN_RD = 1;
  localparam int MAX_RD = 4;
  localparam int MIN_WR = 1;
  localparam int MAX_WR = 2;

  typedef logic [DEF_DATA_W-1:0] word_t;

endpackage
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_if
// Purpose  : Bundles the read, write and allocate signals of regfile_mp.
// Ports    : master - requester side (drives rd_en/rd_addr, wr_*, alloc_*)
//            slave  - register file side (drives rd_data/rd_valid/rd_busy)
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_mp_if #(
  parameter int DATA_W = regfile_pkg::DEF_DATA_W,
  parameter int ADDR_W = regfile_pkg::DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) ();
  import regfile_pkg::*;

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_valid, rd_busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_valid, rd_busy
  );

endinterface
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// ============================================================================
// Module   : regfile_rd_port
// Purpose  : One read port: write forwarding, zero-register masking, busy
//            look-ahead and the registered output stage.
// Ports    : clk, rst_n          - clock, async active-low reset
//            rd_en, rd_addr      - read request for this port
//            mem_data, mem_busy  - stored word / busy bit at rd_addr
//            wr_en/addr/data     - all write ports (for forwarding)
//            alloc_en/addr       - allocation request (busy look-ahead)
//            rd_data, rd_valid, rd_busy - registered results
// Revision : 1.0 - initial release
// ============================================================================
module regfile_rd_port import regfile_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     rd_en,
  input  wire logic [ADDR_W-1:0]        rd_addr,
  input  wire logic [DATA_W-1:0]        mem_data,
  input  wire logic                     mem_busy,
  input  wire logic [NUM_WR-1:0]        wr_en,
  input  wire logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  wire logic [NUM_WR*DATA_W-1:0] wr_data,
  input  wire logic                     alloc_en,
  input  wire logic [ADDR_W-1:0]        alloc_addr,
  output logic      [DATA_W-1:0]        rd_data,
  output logic                          rd_valid,
  output logic                          rd_busy
);

  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] w_fwd_data;
  logic              w_busy_nxt;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_busy;

  // Ascending port loop: the highest-index matching write overrides earlier
  // ones, matching the storage update order. A write to the entry clears the
  // busy look-ahead even when an alloc hits it on the same edge.
  always_comb begin
    w_fwd_data = mem_data;
    w_busy_nxt = mem_busy;
    if (alloc_en && (alloc_addr == rd_addr)) begin
      w_busy_nxt = 1'b1;
    end
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr)) begin
        w_fwd_data = wr_data[w*DATA_W +: DATA_W];
        w_busy_nxt = 1'b0;
      end
    end
    if (ZERO_EN && (rd_addr == '0)) begin
      w_fwd_data = '0;
      w_busy_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_busy  <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_fwd_data;
        r_rd_busy <= w_busy_nxt;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign rd_busy  = r_rd_busy;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-port register file with write forwarding, optional
//            hard-wired zero entry and per-entry busy (pending write) bits.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - regfile_mp_if.slave (read/write/alloc bundle)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input wire logic    clk,
  input wire logic    rst_n,
  regfile_mp_if.slave bus
);

  localparam int DEPTH   = 2**ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic [DATA_W-1:0] w_rd_data [NUM_RD];
  logic [NUM_RD-1:0] w_rd_valid;
  logic [NUM_RD-1:0] w_rd_busy;

  // Storage update. Non-blocking assignments in ascending port order make the
  // highest write port win on an address collision, and the write's busy
  // clear lands after the alloc's set so a same-edge write completes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (bus.alloc_en && !(ZERO_EN && (bus.alloc_addr == '0))) begin
        r_busy[bus.alloc_addr] <= 1'b1;
      end
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] &&
            !(ZERO_EN && (bus.wr_addr[w*ADDR_W +: ADDR_W] == '0))) begin
          r_mem[bus.wr_addr[w*ADDR_W +: ADDR_W]]  <= bus.wr_data[w*DATA_W +: DATA_W];
          r_busy[bus.wr_addr[w*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = bus.rd_addr[p*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_en      (bus.rd_en[p]),
      .rd_addr    (w_addr),
      .mem_data   (r_mem[w_addr]),
      .mem_busy   (r_busy[w_addr]),
      .wr_en      (bus.wr_en),
      .wr_addr    (bus.wr_addr),
      .wr_data    (bus.wr_data),
      .alloc_en   (bus.alloc_en),
      .alloc_addr (bus.alloc_addr),
      .rd_data    (w_rd_data[p]),
      .rd_valid   (w_rd_valid[p]),
      .rd_busy    (w_rd_busy[p])
    );
  end

  always_comb begin
    bus.rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      bus.rd_data[p*DATA_W +: DATA_W] = w_rd_data[p];
    end
  end

  assign bus.rd_valid = w_rd_valid;
  assign bus.rd_busy  = w_rd_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Directed self-checking bench for regfile_mp: a default build
//            (32-bit, 2 read / 2 write ports) and a 16-bit 4R/1W build.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus ();
  regfile_mp_if #(.DATA_W(16), .ADDR_W(5), .NUM_RD(4), .NUM_WR(1)) bus4 ();

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  regfile_mp #(
    .DATA_W(16), .ADDR_W(5), .NUM_RD(4), .NUM_WR(1), .ZERO_REG(1)
  ) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  task automatic idle;
    bus.rd_en       = '0;
    bus.rd_addr     = '0;
    bus.wr_en       = '0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.alloc_en    = 1'b0;
    bus.alloc_addr  = '0;
    bus4.rd_en      = '0;
    bus4.rd_addr    = '0;
    bus4.wr_en      = '0;
    bus4.wr_addr    = '0;
    bus4.wr_data    = '0;
    bus4.alloc_en   = 1'b0;
    bus4.alloc_addr = '0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    idle();
    #2 rst_n = 1'b0;
    // Activity while in reset must be ignored.
    bus.wr_en = 2'b01; bus.wr_addr[4:0] = 5'd12; bus.wr_data[31:0] = 32'h77;
    bus.rd_en = 2'b11; bus.rd_addr = {5'd12, 5'd12};
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd12;
    tick(); tick();
    tests++;
    if (bus.rd_data !== 64'h0) begin
      fails++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data);
    end
    tests++;
    if (bus.rd_valid !== 2'b00) begin
      fails++; $display("FAIL reset_rd_valid: got %b expected 00", bus.rd_valid);
    end
    tests++;
    if (bus.rd_busy !== 2'b00) begin
      fails++; $display("FAIL reset_rd_busy: got %b expected 00", bus.rd_busy);
    end
    tests++;
    if (bus4.rd_valid !== 4'b0000) begin
      fails++; $display("FAIL reset_rd_valid4: got %b expected 0000", bus4.rd_valid);
    end
    idle();
    rst_n = 1'b1;
    bus.rd_en = 2'b01; bus.rd_addr[4:0] = 5'd12;
    tick();
    tests++;
    if (bus.rd_data[31:0] !== 32'h0 || bus.rd_busy[0] !== 1'b0) begin
      fails++; $display("FAIL reset_ignored_wr: got data %h busy %b expected 0 0",
                        bus.rd_data[31:0], bus.rd_busy[0]);
    end
    tests++;
    if (bus.rd_valid !== 2'b01) begin
      fails++; $display("FAIL first_read_valid: got %b expected 01", bus.rd_valid);
    end
    idle();
  endtask

  task automatic test_write_read;
    idle();
    bus.wr_en = 2'b01; bus.wr_addr[4:0] = 5'd5; bus.wr_data[31:0] = 32'hDEADBEEF;
    tick();
    tests++;
    if (bus.rd_valid !== 2'b00) begin
      fails++; $display("FAIL wr_no_valid: got %b expected 00", bus.rd_valid);
    end
    idle();
    bus.rd_en = 2'b01; bus.rd_addr[4:0] = 5'd5;
    tick();
    tests++;
    if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rd_r5_data: got %h expected deadbeef", bus.rd_data[31:0]);
    end
    tests++;
    if (bus.rd_valid !== 2'b01) begin
      fails++; $display("FAIL rd_r5_valid: got %b expected 01", bus.rd_valid);
    end
    idle();
    tick();
    tests++;
    if (bus.rd_valid !== 2'b00 || bus.rd_data[31:0] !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rd_hold: got valid %b data %h expected 00 deadbeef",
                        bus.rd_valid, bus.rd_data[31:0]);
    end
  endtask

  task automatic test_same_edge_write;
    idle();
    bus.wr_en = 2'b11; bus.wr_addr = {5'd7, 5'd7}; bus.wr_data = {32'h22, 32'h11};
    bus.rd_en = 2'b01; bus.rd_addr[4:0] = 5'd7;
    tick();
    tests++;
    if (bus.rd_data[31:0] !== 32'h22) begin
      fails++; $display("FAIL collide_fwd: got %h expected 22", bus.rd_data[31:0]);
    end
    idle();
    bus.rd_en = 2'b10; bus.rd_addr[9:5] = 5'd7;
    tick();
    tests++;
    if (bus.rd_data[63:32] !== 32'h22) begin
      fails++; $display("FAIL collide_stored: got %h expected 22", bus.rd_data[63:32]);
    end
    tests++;
    if (bus.rd_valid !== 2'b10) begin
      fails++; $display("FAIL collide_valid: got %b expected 10", bus.rd_valid);
    end
  endtask

  task automatic test_zero_reg;
    idle();
    bus.wr_en = 2'b01; bus.wr_addr[4:0] = 5'd0; bus.wr_data[31:0] = 32'hFFFFFFFF;
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd0;
    bus.rd_en = 2'b11; bus.rd_addr = {5'd0, 5'd0};
    tick();
    tests++;
    if (bus.rd_data !== 64'h0 || bus.rd_busy !== 2'b00) begin
      fails++; $display("FAIL zero_fwd: got data %h busy %b expected 0 00",
                        bus.rd_data, bus.rd_busy);
    end
    idle();
    bus.rd_en = 2'b11; bus.rd_addr = {5'd0, 5'd0};
    tick();
    tests++;
    if (bus.rd_data !== 64'h0 || bus.rd_busy !== 2'b00) begin
      fails++; $display("FAIL zero_stored: got data %h busy %b expected 0 00",
                        bus.rd_data, bus.rd_busy);
    end
  endtask

  task automatic test_busy;
    idle();
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd9;
    bus.rd_en = 2'b01; bus.rd_addr[4:0] = 5'd9;
    tick();
    tests++;
    if (bus.rd_busy[0] !== 1'b1) begin
      fails++; $display("FAIL busy_same_edge: got %b expected 1", bus.rd_busy[0]);
    end
    idle();
    bus.rd_en = 2'b10; bus.rd_addr[9:5] = 5'd9;
    tick();
    tests++;
    if (bus.rd_busy[1] !== 1'b1) begin
      fails++; $display("FAIL busy_stored: got %b expected 1", bus.rd_busy[1]);
    end
    idle();
    bus.wr_en = 2'b10; bus.wr_addr[9:5] = 5'd9; bus.wr_data[63:32] = 32'h5;
    bus.rd_en = 2'b01; bus.rd_addr[4:0] = 5'd9;
    tick();
    tests++;
    if (bus.rd_data[31:0] !== 32'h5 || bus.rd_busy[0] !== 1'b0) begin
      fails++; $display("FAIL busy_clear_wr: got data %h busy %b expected 5 0",
                        bus.rd_data[31:0], bus.rd_busy[0]);
    end
    // Alloc and write to one entry on the same edge: clear wins.
    idle();
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd10;
    bus.wr_en = 2'b01; bus.wr_addr[4:0] = 5'd10; bus.wr_data[31:0] = 32'hAB;
    bus.rd_en = 2'b10; bus.rd_addr[9:5] = 5'd10;
    tick();
    tests++;
    if (bus.rd_data[63:32] !== 32'hAB || bus.rd_busy[1] !== 1'b0) begin
      fails++; $display("FAIL alloc_wr_fwd: got data %h busy %b expected ab 0",
                        bus.rd_data[63:32], bus.rd_busy[1]);
    end
    idle();
    bus.rd_en = 2'b11; bus.rd_addr = {5'd9, 5'd10};
    tick();
    tests++;
    if (bus.rd_busy !== 2'b00 || bus.rd_data[31:0] !== 32'hAB) begin
      fails++; $display("FAIL alloc_wr_stored: got busy %b data %h expected 00 ab",
                        bus.rd_busy, bus.rd_data[31:0]);
    end
  endtask

  task automatic test_reset_midcycle;
    idle();
    bus.wr_en = 2'b01; bus.wr_addr[4:0] = 5'd3; bus.wr_data[31:0] = 32'hA5;
    tick();
    idle();
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd3;
    bus.rd_en = 2'b01; bus.rd_addr[4:0] = 5'd3;
    tick();
    tests++;
    if (bus.rd_data[31:0] !== 32'hA5 || bus.rd_valid[0] !== 1'b1 || bus.rd_busy[0] !== 1'b1) begin
      fails++; $display("FAIL pre_reset_rd: got data %h valid %b busy %b expected a5 1 1",
                        bus.rd_data[31:0], bus.rd_valid[0], bus.rd_busy[0]);
    end
    // Leave a read request pending, then drop reset between edges.
    bus.alloc_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.rd_data !== 64'h0 || bus.rd_valid !== 2'b00 || bus.rd_busy !== 2'b00) begin
      fails++; $display("FAIL async_reset: got data %h valid %b busy %b expected 0 00 00",
                        bus.rd_data, bus.rd_valid, bus.rd_busy);
    end
    tick();
    idle();
    rst_n = 1'b1;
    tick();
    tests++;
    if (bus.rd_valid !== 2'b00) begin
      fails++; $display("FAIL no_valid_after_reset: got %b expected 00", bus.rd_valid);
    end
    bus.rd_en = 2'b01; bus.rd_addr[4:0] = 5'd3;
    tick();
    tests++;
    if (bus.rd_data[31:0] !== 32'h0 || bus.rd_valid[0] !== 1'b1) begin
      fails++; $display("FAIL r3_cleared: got data %h valid %b expected 0 1",
                        bus.rd_data[31:0], bus.rd_valid[0]);
    end
    idle();
  endtask

  // Write a new entry each cycle while reading it (forwarded) and the entry
  // written the cycle before (stored).
  task automatic test_back_to_back;
    logic [31:0] exp_cur;
    logic [31:0] exp_prev;
    idle();
    bus.wr_en = 2'b01; bus.wr_addr[4:0] = 5'd16; bus.wr_data[31:0] = 32'h1000;
    tick();
    for (int k = 1; k <= 4; k++) begin
      idle();
      exp_cur  = 32'h1000 + 32'(k);
      exp_prev = 32'h1000 + 32'(k - 1);
      bus.wr_en = 2'b01;
      bus.wr_addr[4:0] = 5'(16 + k);
      bus.wr_data[31:0] = exp_cur;
      bus.rd_en = 2'b11;
      bus.rd_addr = {5'(15 + k), 5'(16 + k)};
      tick();
      tests++;
      if (bus.rd_data !== {exp_prev, exp_cur}) begin
        fails++; $display("FAIL b2b_%0d: got %h expected %h", k, bus.rd_data, {exp_prev, exp_cur});
      end
    end
    idle();
  endtask

  task automatic test_four_port;
    logic [4:0]  addrs [4];
    word_t       vals  [4];
    logic [15:0] exp16;
    addrs = '{5'd2, 5'd11, 5'd20, 5'd31};
    vals  = '{32'h1234, 32'hBEEF, 32'h0F0F, 32'hFFFF};
    idle();
    for (int i = 0; i < 4; i++) begin
      bus4.wr_en = 1'b1; bus4.wr_addr = addrs[i]; bus4.wr_data = vals[i][15:0];
      tick();
    end
    idle();
    bus4.rd_en = 4'b1111;
    bus4.rd_addr = {addrs[3], addrs[2], addrs[1], addrs[0]};
    tick();
    for (int p = 0; p < 4; p++) begin
      exp16 = vals[p][15:0];
      tests++;
      if (bus4.rd_data[p*16 +: 16] !== exp16) begin
        fails++; $display("FAIL four_port_%0d: got %h expected %h", p, bus4.rd_data[p*16 +: 16], exp16);
      end
    end
    tests++;
    if (bus4.rd_valid !== 4'b1111) begin
      fails++; $display("FAIL four_port_valid: got %b expected 1111", bus4.rd_valid);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_same_edge_write();
    test_zero_reg();
    test_busy();
    test_back_to_back();
    test_four_port();
    test_reset_midcycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
